// File: rtl/multi_lane_serializer.sv
// ---------------------------------------------------------------------------
// multi_lane_serializer
//   N-lane parallel-to-serial converter for the USB4 logical-layer TX path.
//   One WIDTH-bit word per lane is taken through a valid/ready handshake at
//   each frame boundary and shifted out LSB-first. Frames run back-to-back.
//   If no word is offered at a boundary, an all-zero idle frame is sent and
//   underrun pulses. The block also drives the scrambler seed-reset and enable.
//
// Ports
//   clk          in   clock
//   rst          in   asynchronous, active-low reset
//   enable_ser   in   serializer enable; low = synchronous abort to idle
//   gen_speed    in   00 GEN4, 01 GEN3, 10 GEN2, 11 reserved (GEN4)
//   tx_parallel  in   lane k word = bits [k*WIDTH +: WIDTH]
//   tx_valid     in   tx_parallel holds a word
//   tx_ready     out  word accepted this cycle if tx_valid (combinational)
//   tx_ser       out  serial bit per lane, registered
//   scr_rst      out  one-cycle scrambler seed-reset pulse per frame
//   enable_scr   out  scrambler advance enable
//   underrun     out  one-cycle pulse when an idle frame is inserted
// ---------------------------------------------------------------------------
module multi_lane_serializer #(
  parameter int NUM_LANES = 2,
  parameter int WIDTH     = 132,
  parameter int GEN4_LEN  = 8,
  parameter int GEN3_LEN  = 132,
  parameter int GEN2_LEN  = 66
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable_ser,
  input  logic [1:0]                 gen_speed,
  input  logic [NUM_LANES*WIDTH-1:0] tx_parallel,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic [NUM_LANES-1:0]       tx_ser,
  output logic                       scr_rst,
  output logic                       enable_scr,
  output logic                       underrun
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t                          state_r;
  state_t                          state_s;
  logic [CW-1:0]                   count_r;
  logic [CW-1:0]                   len_r;
  logic [NUM_LANES-1:0][WIDTH-1:0] sr_r;
  logic [NUM_LANES-1:0]            tx_ser_r;
  logic                            scr_rst_r;
  logic                            enable_scr_r;
  logic                            underrun_r;
  logic                            boundary_s;
  logic                            load_s;
  logic                            accept_s;

  // Frame length for a gen_speed code; the reserved code falls back to GEN4.
  function automatic logic [CW-1:0] frame_len(input logic [1:0] gs);
    logic [CW-1:0] len_v;
    case (gs)
      2'b00:   len_v = CW'(GEN4_LEN);
      2'b01:   len_v = CW'(GEN3_LEN);
      2'b10:   len_v = CW'(GEN2_LEN);
      default: len_v = CW'(GEN4_LEN);
    endcase
    return len_v;
  endfunction

  // Frame boundary, handshake and load qualification.
  always_comb begin
    boundary_s = 1'b0;
    load_s     = 1'b0;
    accept_s   = 1'b0;
    if (state_r == ST_IDLE) begin
      boundary_s = 1'b1;
    end else begin
      boundary_s = (count_r == (len_r - CW'(1)));
    end
    // Every boundary edge with the serializer enabled starts a new frame,
    // either with the offered word or with an idle (all-zero) frame.
    load_s   = enable_ser & boundary_s;
    accept_s = load_s & tx_valid;
  end

  assign tx_ready = load_s;

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable_ser) state_s = ST_SHIFT;
        else            state_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (!enable_ser) state_s = ST_IDLE;
        else             state_s = ST_SHIFT;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_s;
  end

  // Shift registers, counter, latched frame length and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_r         <= '0;
      count_r      <= '0;
      len_r        <= CW'(GEN4_LEN);
      tx_ser_r     <= '0;
      scr_rst_r    <= 1'b0;
      enable_scr_r <= 1'b0;
      underrun_r   <= 1'b0;
    end else if (!enable_ser) begin
      // Abort: the partially sent frame is discarded.
      sr_r         <= '0;
      count_r      <= '0;
      len_r        <= len_r;
      tx_ser_r     <= '0;
      scr_rst_r    <= 1'b0;
      enable_scr_r <= 1'b0;
      underrun_r   <= 1'b0;
    end else if (load_s) begin
      // The load edge still emits the previous frame's last bit (0 from
      // idle, since the shift registers are empty there) so frames abut.
      for (int k = 0; k < NUM_LANES; k++) begin
        tx_ser_r[k] <= sr_r[k][0];
        if (accept_s) sr_r[k] <= tx_parallel[k*WIDTH +: WIDTH];
        else          sr_r[k] <= '0;
      end
      count_r      <= '0;
      len_r        <= frame_len(gen_speed);
      scr_rst_r    <= 1'b1;
      enable_scr_r <= 1'b1;
      underrun_r   <= ~tx_valid;
    end else begin
      // Mid-frame shift; only reachable in SHIFT since IDLE is a boundary.
      for (int k = 0; k < NUM_LANES; k++) begin
        tx_ser_r[k] <= sr_r[k][0];
        sr_r[k]     <= {1'b0, sr_r[k][WIDTH-1:1]};
      end
      count_r      <= count_r + CW'(1);
      len_r        <= len_r;
      scr_rst_r    <= 1'b0;
      enable_scr_r <= 1'b1;
      underrun_r   <= 1'b0;
    end
  end

  assign tx_ser     = tx_ser_r;
  assign scr_rst    = scr_rst_r;
  assign enable_scr = enable_scr_r;
  assign underrun   = underrun_r;

endmodule

// File: tb/tb_multi_lane_serializer.sv
module tb_multi_lane_serializer;
  localparam int NL = 2;
  localparam int W  = 132;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            enable_ser = 1'b0;
  logic [1:0]      gen_speed = 2'b00;
  logic [NL*W-1:0] tx_parallel = '0;
  logic            tx_valid = 1'b0;
  logic            tx_ready;
  logic [NL-1:0]   tx_ser;
  logic            scr_rst;
  logic            enable_scr;
  logic            underrun;

  always #5 clk = ~clk;

  multi_lane_serializer #(
    .NUM_LANES(NL), .WIDTH(W), .GEN4_LEN(8), .GEN3_LEN(132), .GEN2_LEN(66)
  ) dut (
    .clk(clk), .rst(rst), .enable_ser(enable_ser), .gen_speed(gen_speed),
    .tx_parallel(tx_parallel), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_ser(tx_ser), .scr_rst(scr_rst), .enable_scr(enable_scr),
    .underrun(underrun)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Scoreboard model: expected serial vectors are queued at each load edge.
  bit            m_shift = 1'b0;
  int            m_cnt = 0;
  int            m_len = 8;
  bit            m_acc = 1'b0;
  logic [NL-1:0] ser_q[$];
  logic [NL-1:0] e_ser = '0;
  logic          e_scr = 1'b0;
  logic          e_und = 1'b0;
  logic          e_es  = 1'b0;

  int         cyc = 0;
  int         scr_q[$];
  int         und_cnt = 0;
  int         rdy_cnt = 0;
  logic [7:0] cap0 = '0;
  logic [7:0] cap1 = '0;
  int         n;
  int         acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int glen(input logic [1:0] g);
    case (g)
      2'b01:   return 132;
      2'b10:   return 66;
      default: return 8;
    endcase
  endfunction

  function automatic bit m_bnd();
    return !m_shift || (m_cnt == m_len - 1);
  endfunction

  function automatic logic [NL*W-1:0] rand_word();
    logic [NL*W-1:0] w;
    for (int i = 0; i < NL*W; i++) w[i] = 1'($urandom_range(0, 1));
    return w;
  endfunction

  task automatic model_reset();
    m_shift = 1'b0; m_cnt = 0; ser_q.delete();
    e_ser = '0; e_scr = 1'b0; e_und = 1'b0; e_es = 1'b0;
  endtask

  // One clock: check tx_ready before the edge, update model at the edge,
  // check registered outputs on the following falling edge.
  task automatic step();
    bit            bnd;
    logic [NL-1:0] v;
    #1;
    bnd = m_bnd();
    chk("tx_ready", tx_ready, enable_ser & bnd);
    if (tx_ready) rdy_cnt++;
    @(posedge clk);
    cyc++;
    m_acc = 1'b0;
    if (!enable_ser) begin
      model_reset();
    end else begin
      e_es = 1'b1;
      if (m_shift && ser_q.size() > 0) e_ser = ser_q.pop_front();
      else                             e_ser = '0;
      if (bnd) begin
        m_len = glen(gen_speed); m_cnt = 0; m_shift = 1'b1;
        e_scr = 1'b1; e_und = !tx_valid; m_acc = tx_valid;
        for (int i = 0; i < m_len; i++) begin
          for (int k = 0; k < NL; k++) v[k] = tx_valid ? tx_parallel[k*W + i] : 1'b0;
          ser_q.push_back(v);
        end
      end else begin
        m_cnt++; e_scr = 1'b0; e_und = 1'b0;
      end
    end
    @(negedge clk);
    chk("tx_ser", tx_ser, e_ser);
    chk("scr_rst", scr_rst, e_scr);
    chk("underrun", underrun, e_und);
    chk("enable_scr", enable_scr, e_es);
    if (scr_rst) scr_q.push_back(cyc);
    if (underrun) und_cnt++;
    cap0 = {tx_ser[0], cap0[7:1]};
    cap1 = {tx_ser[1], cap1[7:1]};
  endtask

  task automatic run_to_boundary(output int steps);
    steps = 0;
    while (!m_bnd() && steps < 300) begin
      step();
      steps++;
    end
    if (steps >= 300) begin
      n_assert++; n_fail++;
      $error("FAIL boundary_timeout: observed %0d steps expected < 300", steps);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_ser", tx_ser, '0);
    chk("rst_scr_rst", scr_rst, 1'b0);
    chk("rst_enable_scr", enable_scr, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b0);
    rst = 1'b1;
    step();

    // GEN4, lane0 = A5, lane1 = 3C, valid held
    gen_speed = 2'b00;
    tx_parallel = '0;
    tx_parallel[0 +: 8] = 8'hA5;
    tx_parallel[W +: 8] = 8'h3C;
    enable_ser = 1'b1; tx_valid = 1'b1;
    step();
    rdy_cnt = 0;
    repeat (8) step();
    chk("gen4_lane0_bits", cap0, 8'hA5);
    chk("gen4_lane1_bits", cap1, 8'h3C);
    repeat (8) step();
    chk("gen4_lane0_bits_f2", cap0, 8'hA5);
    chk("gen4_ready_count", rdy_cnt, 2);
    enable_ser = 1'b0;
    step();

    // GEN2 back-to-back, 3 words
    gen_speed = 2'b10;
    tx_parallel = rand_word();
    enable_ser = 1'b1;
    scr_q.delete(); und_cnt = 0; acc = 0;
    for (int i = 0; i < 400 && acc < 3; i++) begin
      step();
      if (m_acc) begin acc++; tx_parallel = rand_word(); end
    end
    chk("gen2_accepts", acc, 3);
    run_to_boundary(n);
    chk("gen2_scr_pulses", scr_q.size(), 3);
    if (scr_q.size() == 3) begin
      chk("gen2_scr_gap1", scr_q[1] - scr_q[0], 66);
      chk("gen2_scr_gap2", scr_q[2] - scr_q[1], 66);
    end
    chk("gen2_no_underrun", und_cnt, 0);
    step();
    enable_ser = 1'b0;
    step();

    // GEN3 with valid low at the second boundary
    gen_speed = 2'b01;
    tx_parallel = rand_word();
    enable_ser = 1'b1;
    step();
    tx_valid = 1'b0;
    run_to_boundary(n);
    chk("gen3_frame_len", n, 131);
    scr_q.delete(); und_cnt = 0;
    step();
    chk("gen3_underrun_pulse", und_cnt, 1);
    chk("gen3_idle_scr", scr_q.size(), 1);
    tx_valid = 1'b1;
    tx_parallel = rand_word();
    run_to_boundary(n);
    chk("gen3_idle_len", n, 131);
    step();
    chk("gen3_resume_scr", scr_q.size(), 2);
    chk("gen3_single_underrun", und_cnt, 1);

    // gen_speed 01 -> 00 at bit 40 of a GEN3 frame
    repeat (40) step();
    gen_speed = 2'b00;
    tx_parallel = rand_word();
    run_to_boundary(n);
    chk("switch_gen3_completes", n, 91);
    step();
    run_to_boundary(n);
    chk("switch_gen4_len", n, 7);

    // Drop enable at bit 20 of a GEN2 frame
    gen_speed = 2'b10;
    tx_parallel = rand_word();
    step();
    repeat (20) step();
    enable_ser = 1'b0;
    #1;
    chk("abort_ready_same_cycle", tx_ready, 1'b0);
    step();
    chk("abort_tx_ser", tx_ser, '0);
    chk("abort_enable_scr", enable_scr, 1'b0);
    chk("abort_scr_rst", scr_rst, 1'b0);
    enable_ser = 1'b1;
    tx_parallel = rand_word();
    step();
    repeat (66) step();

    // Asynchronous reset mid-frame
    repeat (30) step();
    #2 rst = 1'b0;
    #1;
    chk("async_tx_ser", tx_ser, '0);
    chk("async_scr_rst", scr_rst, 1'b0);
    chk("async_enable_scr", enable_scr, 1'b0);
    chk("async_underrun", underrun, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tx_parallel = rand_word();
    step();
    repeat (70) step();

    enable_ser = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
